// File: rtl/i2c_reg_responder.sv
// rtl/i2c_reg_responder.sv - I2C target turning 16-bit addr/data frames into register-bus commands
// Optional SCL stretching on command backpressure: define I2C_REG_RESPONDER_CLOCK_STRETCH_EN
module i2c_reg_responder #(
    parameter logic [6:0] DEV_ADDR   = 7'h10,
    parameter int         ADDR_BITS  = 15,
    parameter int         DATA_BITS  = 16,
    parameter int         FILTER_LEN = 4
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 scl_i,
    input  logic                 sda_i,
    output logic                 scl_t,
    output logic                 sda_t,
    output logic [ADDR_BITS-1:0] m_addr,
    output logic [DATA_BITS-1:0] m_wdata,
    output logic                 m_we,
    output logic                 m_valid,
    input  logic                 m_ready,
    input  logic [DATA_BITS-1:0] s_rdata,
    input  logic                 s_rvalid,
    output logic                 err_overrun
);

    typedef enum logic [3:0] {
        IDLE, DEVADR, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, ACK, RD_HI, RD_LO, MACK, IGNORE
    } state_t;

    localparam int CW = $clog2(FILTER_LEN + 1);

    // Index 1 = SCL, index 0 = SDA throughout the input path.
    logic [1:0]         sync1_q, sync2_q, filt_q, filt_prev_q;
    logic [1:0][CW-1:0] fcnt_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            filt_q      <= 2'b11;
            filt_prev_q <= 2'b11;
            fcnt_q      <= '0;
        end else begin
            sync1_q     <= {scl_i, sda_i};
            sync2_q     <= sync1_q;
            filt_prev_q <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == CW'(FILTER_LEN - 1)) begin
                    filt_q[i] <= sync2_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
    assign scl_f     = filt_q[1];
    assign sda_f     = filt_q[0];
    assign scl_rise  = scl_f & ~filt_prev_q[1];
    assign scl_fall  = ~scl_f & filt_prev_q[1];
    assign start_det = scl_f & filt_prev_q[1] & filt_prev_q[0] & ~sda_f;
    assign stop_det  = scl_f & filt_prev_q[1] & ~filt_prev_q[0] & sda_f;

    state_t                 state_q, state_d, ret_q, ret_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shreg_q, shreg_d;
    logic [6:0]             tx_q, tx_d;
    logic                   sda_drv_q, sda_drv_d;
    logic [15:0]            addr_word_q, addr_word_d;
    logic [15:0]            data_word_q, data_word_d;
    logic [15:0]            snap_q, snap_d;
    logic [15:0]            rbuf_q, rbuf_d;
    logic                   rd_wait_q, rd_wait_d;
    logic [ADDR_BITS-1:0]   m_addr_q, m_addr_d;
    logic [DATA_BITS-1:0]   m_wdata_q, m_wdata_d;
    logic                   m_we_q, m_we_d;
    logic                   m_valid_q, m_valid_d;
    logic                   err_q, err_d;
    logic                   frame_done, pending, issue;
`ifdef I2C_REG_RESPONDER_CLOCK_STRETCH_EN
    logic                   hold_q, hold_d;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            ret_q       <= IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            tx_q        <= '0;
            sda_drv_q   <= 1'b0;
            addr_word_q <= '0;
            data_word_q <= '0;
            snap_q      <= '0;
            rbuf_q      <= '0;
            rd_wait_q   <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            m_we_q      <= 1'b0;
            m_valid_q   <= 1'b0;
            err_q       <= 1'b0;
`ifdef I2C_REG_RESPONDER_CLOCK_STRETCH_EN
            hold_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            tx_q        <= tx_d;
            sda_drv_q   <= sda_drv_d;
            addr_word_q <= addr_word_d;
            data_word_q <= data_word_d;
            snap_q      <= snap_d;
            rbuf_q      <= rbuf_d;
            rd_wait_q   <= rd_wait_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            m_we_q      <= m_we_d;
            m_valid_q   <= m_valid_d;
            err_q       <= err_d;
`ifdef I2C_REG_RESPONDER_CLOCK_STRETCH_EN
            hold_q      <= hold_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        tx_d        = tx_q;
        sda_drv_d   = sda_drv_q;
        addr_word_d = addr_word_q;
        data_word_d = data_word_q;
        snap_d      = snap_q;
        rbuf_d      = rbuf_q;
        rd_wait_d   = rd_wait_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        m_we_d      = m_we_q;
        err_d       = 1'b0;
        frame_done  = 1'b0;
        issue       = 1'b0;
        pending     = m_valid_q && !m_ready;
        m_valid_d   = pending;
`ifdef I2C_REG_RESPONDER_CLOCK_STRETCH_EN
        hold_d      = hold_q;
`endif

        // Evaluated before the FSM so a same-cycle snapshot sees fresh read data.
        if (rd_wait_q && s_rvalid) begin
            rbuf_d    = s_rdata;
            rd_wait_d = 1'b0;
        end
        if (m_valid_q && m_ready && !m_we_q) begin
            rd_wait_d = 1'b1;
        end

        if (start_det) begin
            state_d   = DEVADR;
            bit_cnt_d = '0;
            sda_drv_d = 1'b0;
        end else if (stop_det) begin
            state_d   = IDLE;
            sda_drv_d = 1'b0;
        end else begin
            case (state_q)
                DEVADR, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shreg_d   = {shreg_q[6:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = '0;
                        state_d   = ACK;
                        sda_drv_d = 1'b1;
                        case (state_q)
                            DEVADR: begin
                                if (shreg_q[7:1] != DEV_ADDR) begin
                                    state_d   = IGNORE;
                                    sda_drv_d = 1'b0;
                                end else if (shreg_q[0]) begin
                                    ret_d  = RD_HI;
                                    snap_d = rbuf_d;
                                end else begin
                                    ret_d = ADDR_HI;
                                end
                            end
                            ADDR_HI: begin
                                addr_word_d[15:8] = shreg_q;
                                ret_d = ADDR_LO;
                            end
                            ADDR_LO: begin
                                addr_word_d[7:0] = shreg_q;
                                ret_d = DATA_HI;
                            end
                            DATA_HI: begin
                                data_word_d[15:8] = shreg_q;
                                ret_d = DATA_LO;
                            end
                            default: begin
                                data_word_d[7:0] = shreg_q;
                                ret_d = IGNORE;
                            end
                        endcase
                    end
                end
                ACK: begin
                    if (scl_fall) begin
                        sda_drv_d = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = ret_q;
                        if (ret_q == RD_HI) begin
                            tx_d      = snap_q[14:8];
                            sda_drv_d = ~snap_q[15];
                        end
                        // Only the DATA_LO acknowledge hands off to IGNORE.
                        frame_done = (ret_q == IGNORE);
                    end
                end
                RD_HI, RD_LO: begin
`ifdef I2C_REG_RESPONDER_CLOCK_STRETCH_EN
                    if (state_q == RD_HI && bit_cnt_q == 4'd0 && rd_wait_q && s_rvalid) begin
                        snap_d    = s_rdata;
                        tx_d      = s_rdata[14:8];
                        sda_drv_d = ~s_rdata[15];
                    end
`endif
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_drv_d = 1'b0;
                            state_d   = MACK;
                            ret_d     = (state_q == RD_HI) ? RD_LO : IGNORE;
                        end else begin
                            sda_drv_d = ~tx_q[6];
                            tx_d      = {tx_q[5:0], 1'b0};
                        end
                    end
                end
                MACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        state_d   = ret_q;
                        if (ret_q == RD_LO) begin
                            tx_d      = snap_q[6:0];
                            sda_drv_d = ~snap_q[7];
                        end
                    end
                end
                IDLE, IGNORE: begin
                    sda_drv_d = 1'b0;
                end
                default: begin
                    state_d   = IDLE;
                    sda_drv_d = 1'b0;
                end
            endcase
        end

        if (frame_done) begin
            if (pending) begin
`ifdef I2C_REG_RESPONDER_CLOCK_STRETCH_EN
                hold_d = 1'b1;
`else
                err_d  = 1'b1;
`endif
            end else begin
                issue = 1'b1;
            end
        end
`ifdef I2C_REG_RESPONDER_CLOCK_STRETCH_EN
        // Frame words stay stable while SCL is held, so they can be issued late.
        if (hold_q && !pending) begin
            issue  = 1'b1;
            hold_d = 1'b0;
        end
`endif
        if (issue) begin
            m_valid_d = 1'b1;
            m_addr_d  = addr_word_q[ADDR_BITS:1];
            m_we_d    = addr_word_q[0];
            m_wdata_d = data_word_q[DATA_BITS-1:0];
        end
    end

`ifdef I2C_REG_RESPONDER_CLOCK_STRETCH_EN
    assign scl_t = ~(hold_q || (state_q == RD_HI && bit_cnt_q == 4'd0 && rd_wait_q));
`else
    assign scl_t = 1'b1;
`endif
    assign sda_t       = ~sda_drv_q;
    assign m_addr      = m_addr_q;
    assign m_wdata     = m_wdata_q;
    assign m_we        = m_we_q;
    assign m_valid     = m_valid_q;
    assign err_overrun = err_q;

endmodule

// File: tb/tb_i2c_reg_responder.sv
// tb/tb_i2c_reg_responder.sv - directed I2C host bench for i2c_reg_responder
module tb_i2c_reg_responder;

    localparam int Q = 20;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        scl_m, sda_m;
    logic        scl_t, sda_t;
    logic [14:0] m_addr;
    logic [15:0] m_wdata;
    logic        m_we, m_valid, m_ready;
    logic [15:0] s_rdata;
    logic        s_rvalid;
    logic        err_overrun;
    logic        scl_bus, sda_bus;

    assign scl_bus = scl_m & scl_t;
    assign sda_bus = sda_m & sda_t;

    i2c_reg_responder dut (
        .aclk(aclk), .aresetn(aresetn), .scl_i(scl_bus), .sda_i(sda_bus),
        .scl_t(scl_t), .sda_t(sda_t), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_we(m_we), .m_valid(m_valid), .m_ready(m_ready), .s_rdata(s_rdata),
        .s_rvalid(s_rvalid), .err_overrun(err_overrun)
    );

    always #5 aclk = ~aclk;

    int          acc_cnt = 0, valid_cyc = 0, ovr_cnt = 0, sda_low_cyc = 0;
    logic [14:0] acc_addr = '0;
    logic        acc_we = 1'b0;
    logic [15:0] acc_wdata = '0;

    always @(negedge aclk) begin
        if (m_valid && m_ready) begin
            acc_cnt   = acc_cnt + 1;
            acc_addr  = m_addr;
            acc_we    = m_we;
            acc_wdata = m_wdata;
        end
        if (m_valid)     valid_cyc   = valid_cyc + 1;
        if (err_overrun) ovr_cnt     = ovr_cnt + 1;
        if (!sda_t)      sda_low_cyc = sda_low_cyc + 1;
    end

    int n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_q(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic clk_pulse(output logic smp);
        wait_q(Q); scl_m = 1'b1;
        wait_q(Q); smp = sda_bus;
        wait_q(Q); scl_m = 1'b0;
        wait_q(Q);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_q(Q);
        scl_m = 1'b1; wait_q(Q);
        sda_m = 1'b0; wait_q(Q);
        scl_m = 1'b0; wait_q(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q(Q);
        scl_m = 1'b1; wait_q(Q);
        sda_m = 1'b1; wait_q(Q);
    endtask

    task automatic write_bits(input logic [7:0] b, input int n);
        logic s;
        for (int i = 0; i < n; i++) begin
            sda_m = b[7-i];
            clk_pulse(s);
        end
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        write_bits(b, 8);
        sda_m = 1'b1;
        clk_pulse(s);
        ack = ~s;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic s;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            sda_m = 1'b1;
            clk_pulse(s);
            d = {d[6:0], s};
        end
        sda_m = nack;
        clk_pulse(s);
    endtask

    task automatic frame5(input logic [7:0] b0, b1, b2, b3, b4, output logic [4:0] acks);
        logic a;
        i2c_start();
        write_byte(b0, a); acks[4] = a;
        write_byte(b1, a); acks[3] = a;
        write_byte(b2, a); acks[2] = a;
        write_byte(b3, a); acks[1] = a;
        write_byte(b4, a); acks[0] = a;
        i2c_stop();
    endtask

    task automatic read_xfer(output logic ack, output logic [7:0] d1, output logic [7:0] d2);
        i2c_start();
        write_byte(8'h21, ack);
        read_byte(d1, 1'b0);
        read_byte(d2, 1'b1);
        i2c_stop();
    endtask

    task automatic rvalid_pulse(input logic [15:0] d);
        s_rdata = d; s_rvalid = 1'b1;
        wait_q(1);
        s_rvalid = 1'b0;
    endtask

    logic [4:0] acks;
    logic [7:0] d1, d2;
    logic       a, a2;
    int         acc0, val0, ovr0, low0;

    initial begin
        aresetn = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
        m_ready = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
        wait_q(4);
        check("rst_scl_t", scl_t, 1);
        check("rst_sda_t", sda_t, 1);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_wdata", m_wdata, 0);
        check("rst_m_we", m_we, 0);
        check("rst_err", err_overrun, 0);
        aresetn = 1'b1;
        wait_q(Q);

        // Write frame
        m_ready = 1'b1;
        acc0 = acc_cnt; val0 = valid_cyc;
        frame5(8'h20, 8'h00, 8'h25, 8'hAA, 8'h55, acks);
        wait_q(10);
        check("wr_acks", acks, 5'b11111);
        check("wr_acc_cnt", acc_cnt - acc0, 1);
        check("wr_valid_cycles", valid_cyc - val0, 1);
        check("wr_addr", acc_addr, 15'h0012);
        check("wr_we", acc_we, 1);
        check("wr_wdata", acc_wdata, 16'hAA55);

        // Stray read strobe with no read outstanding must be ignored
        rvalid_pulse(16'hDEAD);

        // Read command, then read transfer
        acc0 = acc_cnt;
        frame5(8'h20, 8'h80, 8'h00, 8'h00, 8'h00, acks);
        wait_q(10);
        check("rd_cmd_acks", acks, 5'b11111);
        check("rd_acc_cnt", acc_cnt - acc0, 1);
        check("rd_addr", acc_addr, 15'h4000);
        check("rd_we", acc_we, 0);
        rvalid_pulse(16'h1234);
        wait_q(5);
        rvalid_pulse(16'hBEEF);
        read_xfer(a, d1, d2);
        check("rd_devack", a, 1);
        check("rd_byte_hi", d1, 8'h12);
        check("rd_byte_lo", d2, 8'h34);

        // Wrong device address
        acc0 = acc_cnt; low0 = sda_low_cyc;
        frame5(8'h22, 8'h00, 8'h25, 8'h11, 8'h22, acks);
        wait_q(10);
        check("wd_acks", acks, 5'b00000);
        check("wd_sda_low", sda_low_cyc - low0, 0);
        check("wd_acc_cnt", acc_cnt - acc0, 0);

        // Normal frame afterwards, with a sixth byte that must not be ACKed
        acc0 = acc_cnt;
        i2c_start();
        write_byte(8'h20, a);  acks[4] = a;
        write_byte(8'h01, a);  acks[3] = a;
        write_byte(8'h03, a);  acks[2] = a;
        write_byte(8'h03, a);  acks[1] = a;
        write_byte(8'h04, a);  acks[0] = a;
        write_byte(8'h99, a2);
        i2c_stop();
        wait_q(10);
        check("nf_acks", acks, 5'b11111);
        check("nf_extra_nack", a2, 0);
        check("nf_acc_cnt", acc_cnt - acc0, 1);
        check("nf_addr", acc_addr, 15'h0081);
        check("nf_we", acc_we, 1);
        check("nf_wdata", acc_wdata, 16'h0304);

        // Abort by STOP after ADDR_LO, then abort by repeated START, then full frame
        acc0 = acc_cnt;
        i2c_start();
        write_byte(8'h20, a); write_byte(8'h00, a); write_byte(8'h25, a);
        i2c_stop();
        wait_q(10);
        check("ab_stop_acc", acc_cnt - acc0, 0);
        i2c_start();
        write_byte(8'h20, a); write_byte(8'h00, a);
        frame5(8'h20, 8'h00, 8'h27, 8'h11, 8'h22, acks);
        wait_q(10);
        check("ab_rs_acks", acks, 5'b11111);
        check("ab_rs_acc", acc_cnt - acc0, 1);
        check("ab_rs_addr", acc_addr, 15'h0013);
        check("ab_rs_wdata", acc_wdata, 16'h1122);

        // Overrun
        m_ready = 1'b0;
        acc0 = acc_cnt; ovr0 = ovr_cnt;
        frame5(8'h20, 8'h00, 8'h41, 8'h0A, 8'h0B, acks);
        wait_q(10);
        check("ov_first_ovr", ovr_cnt - ovr0, 0);
        frame5(8'h20, 8'h00, 8'h43, 8'h0C, 8'h0D, acks);
        wait_q(10);
        check("ov_pulse", ovr_cnt - ovr0, 1);
        check("ov_valid_held", m_valid, 1);
        check("ov_addr_held", m_addr, 15'h0020);
        check("ov_wdata_held", m_wdata, 16'h0A0B);
        m_ready = 1'b1;
        wait_q(20);
        check("ov_acc_cnt", acc_cnt - acc0, 1);
        check("ov_acc_addr", acc_addr, 15'h0020);

        // Reset during DATA_HI with a pending command
        m_ready = 1'b0;
        acc0 = acc_cnt;
        frame5(8'h20, 8'h00, 8'h45, 8'h01, 8'h02, acks);
        wait_q(10);
        check("rs_pending", m_valid, 1);
        i2c_start();
        write_byte(8'h20, a); write_byte(8'h00, a); write_byte(8'h25, a);
        write_bits(8'hFF, 4);
        aresetn = 1'b0;
        #1;
        check("rs_sda_t", sda_t, 1);
        check("rs_m_valid", m_valid, 0);
        check("rs_m_addr", m_addr, 0);
        wait_q(3);
        aresetn = 1'b1;
        m_ready = 1'b1;
        i2c_stop();
        wait_q(20);
        check("rs_no_cmd", acc_cnt - acc0, 0);
        read_xfer(a, d1, d2);
        check("rs_rd_ack", a, 1);
        check("rs_rd_hi", d1, 8'h00);
        check("rs_rd_lo", d2, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
